// File: rtl/arrow_key_conditioner.sv
// arrow_key_conditioner
//   Purpose : conditions the four raw arrow buttons into single-tick arrow codes
//             for the page modules (synchronise, debounce, edge-detect, queue, deliver).
//   Ports   : clk, rst (async active-low), prog_tick (one-clk strobe per prog_clk period),
//             raw_btn[3:0] {RIGHT,LEFT,DOWN,UP} in; arrow_keys[2:0] (0 = no key),
//             btn_level[3:0] debounced levels, pending[3:0] queued presses out.
//   Option  : define AUTOREPEAT_EN to generate per-button hold counters that re-queue
//             a held button after REPEAT_DELAY ticks and then every REPEAT_PERIOD ticks.
module arrow_key_conditioner #(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_tick,
  input  logic [3:0] raw_btn,
  output logic [2:0] arrow_keys,
  output logic [3:0] btn_level,
  output logic [3:0] pending
);

  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;

  localparam int          CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("arrow_key_conditioner: parameters out of range");
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. sync_ok marks when sync2 holds real pin data rather
  // than its reset value, so the re-arm logic below cannot be fooled by it.
  // ---------------------------------------------------------------------------
  logic [3:0] sync1, sync2;
  logic [1:0] sync_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      sync_ok <= '0;
    end else begin
      sync1   <= raw_btn;
      sync2   <= sync1;
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the level flips only after DB_CYCLES consecutive differing
  // samples. The counter clears at DB_LAST, so it can never wrap.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] db_cnt [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i] <= ~btn_level[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press detection. A button held through reset must not produce an event
  // when its debounced level comes up afterwards, so each bit is only armed
  // once the pin has been seen released after reset.
  // ---------------------------------------------------------------------------
  logic [3:0] level_d;
  logic [3:0] armed;
  logic [3:0] press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_d <= '0;
      armed   <= '0;
    end else begin
      level_d <= btn_level;
      armed   <= armed | ({4{sync_ok[1]}} & ~sync2 & ~btn_level);
    end
  end

  assign press = btn_level & ~level_d & armed;

  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
  logic [3:0] rep_set;

`ifdef AUTOREPEAT_EN
  localparam int            HW        = $clog2(REPEAT_DELAY + 1);
  localparam int            PW        = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(REPEAT_PERIOD - 1);

  // hold_cnt saturates at REPEAT_DELAY; per_cnt then paces the repeats.
  logic [HW-1:0] hold_cnt [4];
  logic [PW-1:0] per_cnt  [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        hold_cnt[i] <= '0;
        per_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!btn_level[i] || !armed[i]) begin
          hold_cnt[i] <= '0;
          per_cnt[i]  <= '0;
        end else if (prog_tick) begin
          if (hold_cnt[i] != HOLD_MAX) begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end else if (per_cnt[i] == PER_LAST) begin
            per_cnt[i] <= '0;
          end else begin
            per_cnt[i] <= per_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rep_set = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_level[i] && armed[i] && prog_tick &&
          (hold_cnt[i] == HOLD_FIRE ||
           (hold_cnt[i] == HOLD_MAX && per_cnt[i] == PER_LAST))) begin
        rep_set[i] = 1'b1;
      end
    end
  end
`else
  assign rep_set = '0;
`endif

  // ---------------------------------------------------------------------------
  // Delivery FSM. SHOW always returns to IDLE with a zero code so that two
  // deliveries of the same key are separated by a visible gap.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE,
    S_SHOW
  } state_t;

  state_t     state, state_n;
  logic [2:0] arrow_n;
  logic [3:0] clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      arrow_keys <= KEY_NONE;
      pending    <= '0;
    end else begin
      state      <= state_n;
      arrow_keys <= arrow_n;
      // A new press landing on its own delivery tick wins over the clear.
      pending    <= (pending & ~clr) | press | rep_set;
    end
  end

  always_comb begin
    state_n = state;
    arrow_n = arrow_keys;
    clr     = '0;
    if (prog_tick) begin
      case (state)
        S_IDLE: begin
          arrow_n = KEY_NONE;
          if (pending != '0) begin
            state_n = S_SHOW;
            if (pending[0]) begin
              arrow_n = KEY_UP;
              clr     = 4'b0001;
            end else if (pending[1]) begin
              arrow_n = KEY_DOWN;
              clr     = 4'b0010;
            end else if (pending[2]) begin
              arrow_n = KEY_LEFT;
              clr     = 4'b0100;
            end else begin
              arrow_n = KEY_RIGHT;
              clr     = 4'b1000;
            end
          end
        end
        S_SHOW: begin
          state_n = S_IDLE;
          arrow_n = KEY_NONE;
        end
        default: begin
          state_n = S_IDLE;
          arrow_n = KEY_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arrow_key_conditioner.sv
// tb_arrow_key_conditioner
//   Purpose : directed check of debounce timing, single delivery per press, priority
//             queueing, async reset with a held button, and hold behaviour (with or
//             without AUTOREPEAT_EN). DB_CYCLES=4, prog_tick every 10 clk.
module tb_arrow_key_conditioner;

  localparam int K_UP    = 1;
  localparam int K_DOWN  = 2;
  localparam int K_LEFT  = 3;
  localparam int K_RIGHT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prog_tick = 1'b0;
  logic [3:0] raw_btn = 4'b0000;
  logic [2:0] arrow_keys;
  logic [3:0] btn_level;
  logic [3:0] pending;

  arrow_key_conditioner #(.DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_tick  (prog_tick),
    .raw_btn    (raw_btn),
    .arrow_keys (arrow_keys),
    .btn_level  (btn_level),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tcnt  = 0;
  bit   tick_en = 1'b1;
  bit   edge_tick = 1'b0;
  int   off_tick = 0;
  int   prev_arrow = 0;
  int   ev_val[$];
  int   ev_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample on the falling edge, log arrow_keys changes, then drive
  // prog_tick for the next rising edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      edge_tick = prog_tick;
      if (int'(arrow_keys) != prev_arrow) begin
        ev_val.push_back(int'(arrow_keys));
        ev_cyc.push_back(cyc);
        if (!edge_tick) off_tick++;
        prev_arrow = int'(arrow_keys);
      end
      tcnt      = (tcnt == 9) ? 0 : tcnt + 1;
      prog_tick = tick_en && (tcnt == 9);
    end
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 20; k++) begin
      step();
      if (edge_tick) return;
    end
    chk("wait_tick_timeout", 0, 1);
  endtask

  task automatic clear_log();
    ev_val.delete();
    ev_cyc.delete();
  endtask

  function automatic int ev_v(input int i);
    if (i < ev_val.size()) return ev_val[i];
    return -1;
  endfunction

  function automatic int ev_c(input int i);
    if (i < ev_cyc.size()) return ev_cyc[i];
    return -1;
  endfunction

  function automatic int count_code(input int code);
    int n = 0;
    foreach (ev_val[i]) if (ev_val[i] == code) n++;
    return n;
  endfunction

  initial begin
    int c0;
    int flips;
    bit found;
    int nth;

    // ---- reset state
    step(3);
    chk("rst_arrow", arrow_keys, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b1;
    step(5);

    // ---- 1: clean UP press
    clear_log();
    wait_tick();
    c0 = cyc;
    raw_btn = 4'b0001;
    step(5);
    chk("t1_level_before", btn_level[0], 0);
    step();
    chk("t1_level_rise", btn_level[0], 1);
    step();
    chk("t1_pending_set", pending, 4'b0001);
    step(93);
    raw_btn = 4'b0000;
    step(40);
    chk("t1_code", ev_v(0), K_UP);
    chk("t1_latency", ev_c(0) - c0, 10);
    chk("t1_gap_code", ev_v(1), 0);
    chk("t1_hold_len", ev_c(1) - ev_c(0), 10);
    chk("t1_event_count", ev_val.size(), 2);

    // ---- 2: bouncing DOWN
    clear_log();
    wait_tick();
    flips = 0;
    for (int k = 0; k < 10; k++) begin
      raw_btn[1] = ~k[0];
      for (int j = 0; j < 2; j++) begin
        step();
        if (btn_level[1]) flips++;
      end
    end
    raw_btn[1] = 1'b1;
    step(60);
    raw_btn = 4'b0000;
    step(40);
    chk("t2_no_flip_in_bounce", flips, 0);
    chk("t2_down_count", count_code(K_DOWN), 1);
    chk("t2_event_count", ev_val.size(), 2);

    // ---- 3: UP and RIGHT together
    clear_log();
    wait_tick();
    c0 = cyc;
    raw_btn = 4'b1001;
    step(45);
    chk("t3_pending_empty", pending, 0);
    chk("t3_first", ev_v(0), K_UP);
    chk("t3_gap", ev_v(1), 0);
    chk("t3_second", ev_v(2), K_RIGHT);
    chk("t3_end", ev_v(3), 0);
    chk("t3_right_time", ev_c(2) - c0, 30);
    chk("t3_end_time", ev_c(3) - c0, 40);
    raw_btn = 4'b0000;
    step(30);

    // ---- 4: reset while LEFT is shown and queued again
    clear_log();
    wait_tick();
    raw_btn = 4'b0100;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (arrow_keys == 3'(K_LEFT)) found = 1'b1;
    end
    chk("t4_left_shown", found, 1);
    tick_en   = 1'b0;
    prog_tick = 1'b0;
    raw_btn = 4'b0000;
    step(12);
    raw_btn = 4'b0100;
    step(12);
    chk("t4_pending_left", pending, 4'b0100);
    chk("t4_still_left", arrow_keys, K_LEFT);
    #2 rst = 1'b0;
    #1;
    chk("t4_rst_arrow", arrow_keys, 0);
    chk("t4_rst_pending", pending, 0);
    chk("t4_rst_level", btn_level, 0);
    prev_arrow = 0;
    step(3);
    rst = 1'b1;
    clear_log();
    tick_en = 1'b1;
    step(100);
    chk("t4_no_event_held", ev_val.size(), 0);
    chk("t4_no_pending_held", pending, 0);
    raw_btn = 4'b0000;
    step(20);
    raw_btn = 4'b0100;
    step(40);
    chk("t4_repress", ev_v(0), K_LEFT);
    raw_btn = 4'b0000;
    step(30);

    // ---- 5/6: DOWN held for about 19 ticks
    clear_log();
    wait_tick();
    c0 = cyc;
    raw_btn = 4'b0010;
    step(185);
    raw_btn = 4'b0000;
    step(60);
`ifdef AUTOREPEAT_EN
    chk("t5_down_count", count_code(K_DOWN), 5);
    nth = 0;
    foreach (ev_val[i]) begin
      if (ev_val[i] == K_DOWN) begin
        if (nth == 1) chk("t5_first_repeat", ev_cyc[i] - c0, 90);
        if (nth == 4) chk("t5_last_repeat", ev_cyc[i] - c0, 180);
        nth++;
      end
    end
`else
    nth = 0;
    chk("t6_down_count", count_code(K_DOWN), 1);
    chk("t6_first_time", ev_c(0) - c0, 10);
`endif

    chk("arrow_changes_on_tick_only", off_tick, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
